// File: rtl/i2s_transmitter.sv
// I2S serialiser: shifts stereo pairs out MSB first, paced by falling edges of an externally
// divided bit clock that is synchronised into the system clock domain.
module i2s_transmitter #(
    parameter int unsigned DATA_WIDTH = 24,
    parameter int unsigned SLOT_WIDTH = 32
) (
    input  logic                  clkIn,
    input  logic                  reset,
    input  logic                  bclkIn,
    input  logic [DATA_WIDTH-1:0] leftIn,
    input  logic [DATA_WIDTH-1:0] rightIn,
    input  logic                  inValid,
    output logic                  inReady,
    output logic                  wsOut,
    output logic                  sdataOut,
    output logic                  frameStart,
    output logic                  underrun
);

    localparam int unsigned FrameLen = 2 * SLOT_WIDTH;
    localparam int unsigned CntW     = $clog2(FrameLen);

    localparam logic [CntW-1:0] LastBit = CntW'(FrameLen - 1);
    localparam logic [CntW-1:0] WsFirst = CntW'(SLOT_WIDTH - 1);
    localparam logic [CntW-1:0] WsLast  = CntW'(FrameLen - 2);

    logic                  bclkS1, bclkS2, bclkS3;
    logic                  fallEdge;
    logic [CntW-1:0]       bitCount, countNext;
    logic                  frameBegin;
    logic                  handshake;

    logic                  pendingFull;
    logic [DATA_WIDTH-1:0] pendingL, pendingR;
    logic [DATA_WIDTH-1:0] activeL, activeR;
    logic [DATA_WIDTH-1:0] loadL, loadR;

    logic [DATA_WIDTH+SLOT_WIDTH-1:0] padL, padR;
    logic [SLOT_WIDTH-1:0]            slotL, slotR;
    logic [FrameLen-1:0]              frameBits;
    logic [CntW-1:0]                  bitIdx;
    logic                             bitNext;
    logic                             wsNext;

    assign fallEdge   = bclkS3 & ~bclkS2;
    assign countNext  = (bitCount == LastBit) ? '0 : bitCount + CntW'(1);
    assign frameBegin = fallEdge & (countNext == '0);

    assign inReady    = ~reset & ~pendingFull;
    assign handshake  = inValid & inReady;

    // Pair that will be active after this cycle; bit 0 of a frame is taken from it directly.
    always_comb begin
        loadL = activeL;
        loadR = activeR;
        if (frameBegin) begin
            if (pendingFull) begin
                loadL = pendingL;
                loadR = pendingR;
            end else if (handshake) begin
                loadL = leftIn;
                loadR = rightIn;
            end else begin
                loadL = '0;
                loadR = '0;
            end
        end
    end

    // Left-justify each sample in its slot, zero padding below the LSB.
    always_comb begin
        padL      = {loadL, {SLOT_WIDTH{1'b0}}};
        padR      = {loadR, {SLOT_WIDTH{1'b0}}};
        slotL     = padL[DATA_WIDTH+SLOT_WIDTH-1 -: SLOT_WIDTH];
        slotR     = padR[DATA_WIDTH+SLOT_WIDTH-1 -: SLOT_WIDTH];
        frameBits = {slotL, slotR};
        bitIdx    = LastBit - countNext;
        bitNext   = frameBits[bitIdx];
        wsNext    = (countNext >= WsFirst) && (countNext <= WsLast);
    end

    always_ff @(posedge clkIn) begin
        if (reset) begin
            bclkS1      <= 1'b0;
            bclkS2      <= 1'b0;
            bclkS3      <= 1'b0;
            bitCount    <= LastBit;
            pendingFull <= 1'b0;
            pendingL    <= '0;
            pendingR    <= '0;
            activeL     <= '0;
            activeR     <= '0;
            wsOut       <= 1'b0;
            sdataOut    <= 1'b0;
            frameStart  <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            bclkS1     <= bclkIn;
            bclkS2     <= bclkS1;
            bclkS3     <= bclkS2;
            frameStart <= 1'b0;
            underrun   <= 1'b0;

            if (fallEdge) begin
                bitCount <= countNext;
                wsOut    <= wsNext;
                sdataOut <= bitNext;
            end

            if (frameBegin) begin
                activeL    <= loadL;
                activeR    <= loadR;
                frameStart <= 1'b1;
                underrun   <= ~pendingFull & ~handshake;
            end

            // A handshake coinciding with a frame start bypasses pending entirely.
            if (frameBegin && pendingFull) begin
                pendingFull <= 1'b0;
            end else if (handshake && !frameBegin) begin
                pendingL    <= leftIn;
                pendingR    <= rightIn;
                pendingFull <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_i2s_transmitter.sv
// Directed bench for i2s_transmitter: drives a software bit clock, logs each frame bit just
// before the period ends and compares whole frames against hand-derived patterns.
module tb_i2s_transmitter;

    localparam int FL = 64;
    localparam logic [63:0] ExpWs = 64'h7FFF_FFFF_8000_0000;

    logic        clkIn = 1'b0;
    logic        reset = 1'b1;
    logic        bclkIn = 1'b1;
    logic [23:0] leftIn = '0;
    logic [23:0] rightIn = '0;
    logic        inValid = 1'b0;
    logic        inReady, wsOut, sdataOut, frameStart, underrun;

    int          testCount = 0;
    int          failCount = 0;
    int          fsCount = 0;
    int          urCount = 0;
    int          cyc = 0;
    int          lastFsCyc = 0;
    int          lastHsCyc = 0;
    int          half = 4;
    int          tbK = FL - 1;
    bit          autoDrop = 1'b0;
    logic [63:0] logSd = '0;
    logic [63:0] logWs = '0;

    i2s_transmitter #(
        .DATA_WIDTH(24),
        .SLOT_WIDTH(32)
    ) dut (
        .clkIn      (clkIn),
        .reset      (reset),
        .bclkIn     (bclkIn),
        .leftIn     (leftIn),
        .rightIn    (rightIn),
        .inValid    (inValid),
        .inReady    (inReady),
        .wsOut      (wsOut),
        .sdataOut   (sdataOut),
        .frameStart (frameStart),
        .underrun   (underrun)
    );

    always #5 clkIn = ~clkIn;

    task automatic checkValue(input string tag, input logic [63:0] got, input logic [63:0] exp);
        testCount++;
        if (got !== exp) begin
            failCount++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Expected serial frame, indexed by bit number k.
    function automatic logic [63:0] expFrame(input logic [23:0] l, input logic [23:0] r);
        logic [63:0] f;
        f = '0;
        for (int k = 0; k < 24; k++) begin
            f[k]      = l[23-k];
            f[32 + k] = r[23-k];
        end
        return f;
    endfunction

    task automatic step();
        bit hs;
        hs = inValid && inReady;
        @(posedge clkIn);
        #1;
        cyc++;
        if (frameStart) begin
            fsCount++;
            lastFsCyc = cyc;
        end
        if (underrun) urCount++;
        if (hs) begin
            lastHsCyc = cyc;
            if (autoDrop) begin
                inValid  = 1'b0;
                autoDrop = 1'b0;
            end
        end
    endtask

    task automatic fallBit();
        bclkIn = 1'b0;
        tbK    = (tbK + 1) % FL;
        repeat (half) step();
        bclkIn = 1'b1;
        repeat (half) step();
        logSd[tbK] = sdataOut;
        logWs[tbK] = wsOut;
    endtask

    task automatic runFrame();
        repeat (FL) fallBit();
    endtask

    task automatic clearCounts();
        fsCount = 0;
        urCount = 0;
    endtask

    task automatic pushPair(input logic [23:0] l, input logic [23:0] r);
        checkValue("pushReady", 64'(inReady), 64'd1);
        leftIn  = l;
        rightIn = r;
        inValid = 1'b1;
        step();
        inValid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) step();
        checkValue("resetOuts", 64'({wsOut, sdataOut, frameStart, underrun, inReady}), 64'd0);
        reset = 1'b0;
        step();
        checkValue("readyAfterReset", 64'(inReady), 64'd1);
        repeat (3) step();

        // Idle: two underrun frames of pure padding.
        for (int f = 0; f < 2; f++) begin
            clearCounts();
            runFrame();
            checkValue("idleSd", logSd, 64'd0);
            checkValue("idleWs", logWs, ExpWs);
            checkValue("idleFs", 64'(fsCount), 64'd1);
            checkValue("idleUr", 64'(urCount), 64'd1);
        end

        // Preloaded boundary pair.
        pushPair(24'h800001, 24'h7FFFFF);
        clearCounts();
        runFrame();
        checkValue("preloadSd", logSd, 64'h00FF_FFFE_0080_0001);
        checkValue("preloadWs", logWs, ExpWs);
        checkValue("preloadFs", 64'(fsCount), 64'd1);
        checkValue("preloadUr", 64'(urCount), 64'd0);

        // Handshake on the very cycle of the k=0 update.
        clearCounts();
        bclkIn = 1'b0;
        tbK    = 0;
        step();
        step();
        leftIn  = 24'hA5A5A5;
        rightIn = 24'h3C3C3C;
        inValid = 1'b1;
        step();
        checkValue("directFs", 64'(frameStart), 64'd1);
        checkValue("directUr", 64'(underrun), 64'd0);
        checkValue("directMsb", 64'(sdataOut), 64'd1);
        checkValue("directReady", 64'(inReady), 64'd1);
        inValid = 1'b0;
        step();
        bclkIn = 1'b1;
        repeat (4) step();
        logSd[0] = sdataOut;
        logWs[0] = wsOut;
        repeat (FL - 1) fallBit();
        checkValue("directSd", logSd, expFrame(24'hA5A5A5, 24'h3C3C3C));
        checkValue("directUrCnt", 64'(urCount), 64'd0);

        // Back-to-back pairs: second waits for the frame-start transfer.
        leftIn  = 24'h111111;
        rightIn = 24'h222222;
        inValid = 1'b1;
        step();
        checkValue("b2bReadyLow", 64'(inReady), 64'd0);
        leftIn   = 24'h333333;
        rightIn  = 24'h444444;
        autoDrop = 1'b1;
        repeat (3) step();
        checkValue("b2bStillLow", 64'(inReady), 64'd0);
        clearCounts();
        runFrame();
        checkValue("b2bFrame1", logSd, expFrame(24'h111111, 24'h222222));
        checkValue("b2bUr1", 64'(urCount), 64'd0);
        checkValue("b2bAcceptGap", 64'(lastHsCyc - lastFsCyc), 64'd1);
        clearCounts();
        runFrame();
        checkValue("b2bFrame2", logSd, expFrame(24'h333333, 24'h444444));
        checkValue("b2bUr2", 64'(urCount), 64'd0);

        // Reset in the middle of a frame with a pair still pending.
        pushPair(24'hC3C3C3, 24'hFFFFFF);
        repeat (41) fallBit();
        checkValue("midWs", 64'(wsOut), 64'd1);
        checkValue("midSd", 64'(sdataOut), 64'd1);
        pushPair(24'h0F0F0F, 24'hF0F0F0);
        reset = 1'b1;
        step();
        checkValue("rstOuts", 64'({wsOut, sdataOut, frameStart, underrun, inReady}), 64'd0);
        repeat (2) step();
        reset = 1'b0;
        tbK   = FL - 1;
        repeat (4) step();
        clearCounts();
        fallBit();
        checkValue("restartFs", 64'(fsCount), 64'd1);
        checkValue("restartUr", 64'(urCount), 64'd1);
        repeat (FL - 1) fallBit();
        checkValue("restartSd", logSd, 64'd0);
        checkValue("restartWs", logWs, ExpWs);

        // Latency and minimum bit-clock phases.
        half = 2;
        pushPair(24'hDEADBE, 24'h135790);
        clearCounts();
        bclkIn = 1'b0;
        tbK    = 0;
        step();
        checkValue("lat1Sd", 64'(sdataOut), 64'd0);
        step();
        checkValue("lat2Sd", 64'(sdataOut), 64'd0);
        checkValue("lat2Fs", 64'(frameStart), 64'd0);
        bclkIn = 1'b1;
        step();
        checkValue("lat3Sd", 64'(sdataOut), 64'd1);
        checkValue("lat3Fs", 64'(frameStart), 64'd1);
        step();
        logSd[0] = sdataOut;
        logWs[0] = wsOut;
        repeat (FL - 1) fallBit();
        checkValue("fastSd", logSd, expFrame(24'hDEADBE, 24'h135790));
        checkValue("fastWs", logWs, ExpWs);
        checkValue("fastUr", 64'(urCount), 64'd0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
